// File: rtl/mips_memory_port_arbiter.sv
// rtl/mips_memory_port_arbiter.sv - round-robin arbiter sharing one data memory port between fetch and data stage
//
// Purpose: grants the single byte-addressable memory port to either the
// instruction-fetch side (word reads only) or the data-stage side (loads and
// stores with byte enable / extension). Round-robin between the two, with a
// bounded lock that lets the data side hold the port for atomic sequences.
// The winner drives the memory port combinationally; read data comes back
// registered one cycle after the grant.
//
// Ports:
//   ctrl              clock and synchronous active-high reset
//   i_req / i_addr    fetch request and word-aligned byte address
//   i_gnt             fetch granted this cycle
//   i_rvalid/i_rdata  fetched word, the cycle after i_gnt
//   d_req / d_lock    data request; d_lock keeps the port for the next request
//   d_addr/d_control/d_data  data byte address, memory control, store data
//   d_gnt             data granted this cycle
//   d_rvalid/d_rdata  load result (or store acknowledge), the cycle after d_gnt
//   m_addr/m_control/m_data  memory port, driven by the winner
//   m_out             memory read result for the current m_addr

package mips_memory_port_arbiter_pkg;

  typedef struct packed {
    logic clk;
    logic reset;
  } control_t;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BE_NONE = 2'd0,
    BE_BYTE = 2'd1,
    BE_HALF = 2'd2,
    BE_WORD = 2'd3
  } byte_enable_t;

  typedef enum logic {
    EXT_UNSIGNED = 1'b0,
    EXT_SIGNED   = 1'b1
  } byte_extend_t;

  typedef struct packed {
    byte_enable_t byte_enable;
    byte_extend_t byte_extend;
    logic         write_enable;
  } memory_control_t;

endpackage

module mips_memory_port_arbiter
  import mips_memory_port_arbiter_pkg::*;
#(
  parameter int ADDR_L   = 64,
  parameter int ADDR_W   = $clog2(ADDR_L),
  parameter int LOCK_MAX = 4
) (
  input  control_t          ctrl,
  input  logic              i_req,
  input  logic [ADDR_W+1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output word_t             i_rdata,
  input  logic              d_req,
  input  logic              d_lock,
  input  logic [ADDR_W+1:0] d_addr,
  input  memory_control_t   d_control,
  input  word_t             d_data,
  output logic              d_gnt,
  output logic              d_rvalid,
  output word_t             d_rdata,
  output logic [ADDR_W+1:0] m_addr,
  output memory_control_t   m_control,
  output word_t             m_data,
  input  word_t             m_out
);

  localparam int CW = $clog2(LOCK_MAX) + 1;

  typedef enum logic {
    ST_RR     = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  logic          clk;
  logic          rst;
  state_t        state, state_next;
  side_t         last, last_next;
  logic [CW-1:0] lock_cnt, lock_cnt_next;
  logic          i_rvalid_q, d_rvalid_q;

  assign clk = ctrl.clk;
  assign rst = ctrl.reset;

  always_comb begin
    i_gnt         = 1'b0;
    d_gnt         = 1'b0;
    state_next    = state;
    last_next     = last;
    lock_cnt_next = lock_cnt;
    if (!rst) begin
      case (state)
        ST_RR: begin
          if (i_req && d_req) begin
            if (last == SIDE_D) i_gnt = 1'b1;
            else                d_gnt = 1'b1;
          end else begin
            i_gnt = i_req;
            d_gnt = d_req;
          end
          if (d_gnt && d_lock) begin
            state_next    = ST_LOCKED;
            lock_cnt_next = CW'(1);
          end
        end
        ST_LOCKED: begin
          if (lock_cnt >= CW'(LOCK_MAX)) begin
            // Forced release: no grant this cycle; last stays D so fetch wins the next tie.
            state_next    = ST_RR;
            last_next     = SIDE_D;
            lock_cnt_next = '0;
          end else if (d_req) begin
            d_gnt = 1'b1;
            if (d_lock) begin
              lock_cnt_next = lock_cnt + CW'(1);
            end else begin
              state_next    = ST_RR;
              lock_cnt_next = '0;
            end
          end else begin
            // Idle cycles inside a lock still consume the lock budget.
            lock_cnt_next = lock_cnt + CW'(1);
          end
        end
        default: begin
          state_next = ST_RR;
        end
      endcase
      if (i_gnt)      last_next = SIDE_I;
      else if (d_gnt) last_next = SIDE_D;
    end
  end

  always_comb begin
    m_addr    = '0;
    m_data    = '0;
    m_control = '{byte_enable: BE_NONE, byte_extend: EXT_UNSIGNED, write_enable: 1'b0};
    if (d_gnt) begin
      m_addr    = d_addr;
      m_data    = d_data;
      m_control = d_control;
    end else if (i_gnt) begin
      m_addr    = i_addr;
      m_control = '{byte_enable: BE_WORD, byte_extend: EXT_UNSIGNED, write_enable: 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RR;
      last       <= SIDE_D;
      lock_cnt   <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_next;
      last       <= last_next;
      lock_cnt   <= lock_cnt_next;
      i_rvalid_q <= i_gnt;
      d_rvalid_q <= d_gnt;
      if (i_gnt) i_rdata <= m_out;
      if (d_gnt) d_rdata <= m_out;
    end
  end

  // A return registered just before reset must not be presented while reset is held.
  assign i_rvalid = i_rvalid_q & ~rst;
  assign d_rvalid = d_rvalid_q & ~rst;

endmodule
